instr_pipe_regs: RTL and testbench

Instruction pipeline register chain for the 5-stage RV32I core. It carries each fetched instruction, its PC and a valid bit through stages 1–4 (D, E, M, W), and supplies the per-stage opcodes consumed by the control decoder. It also performs load-use hazard detection and inserts the stall bubble, squashes wrong-path instructions on a taken redirect, and counts retired instructions.

---
 rtl/instr_pipe_regs.sv | 123 ++++++++++++
 tb/tb_instr_pipe_regs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_pipe_regs.sv
// instr_pipe_regs
// Instruction/PC/valid register chain for the D, E, M and W stages of the
// 5-stage RV32I core. Detects the load-use hazard between E and D, inserts a
// one-cycle bubble into E while D holds, squashes the two younger slots on a
// taken redirect, and counts instructions that retire out of W.
module instr_pipe_regs #(
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic        valid_f,
  input  logic        redirect,
  output logic        stall,
  output logic [31:0] instr_d,
  output logic [31:0] instr_e,
  output logic [31:0] instr_m,
  output logic [31:0] instr_w,
  output logic [31:0] pc_d,
  output logic [31:0] pc_e,
  output logic [31:0] pc_m,
  output logic [31:0] pc_w,
  output logic        valid_d,
  output logic        valid_e,
  output logic        valid_m,
  output logic        valid_w,
  output logic [6:0]  opcode,
  output logic [6:0]  opcode1,
  output logic [6:0]  opcode2,
  output logic [6:0]  opcode3,
  output logic [6:0]  opcode4,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [4:0] rd_e;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_use;

  assign opcode  = instr_f[6:0];
  assign opcode1 = instr_d[6:0];
  assign opcode2 = instr_e[6:0];
  assign opcode3 = instr_m[6:0];
  assign opcode4 = instr_w[6:0];

  assign rd_e  = instr_e[11:7];
  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];

  // Work out which source fields of the D instruction are real reads, then flag a load in E feeding one of them
  always_comb begin
    uses_rs1 = !((opcode1 == OP_LUI) || (opcode1 == OP_AUIPC) || (opcode1 == OP_JAL));
    uses_rs2 = (opcode1 == OP_RTYPE) || (opcode1 == OP_STORE) || (opcode1 == OP_BRANCH);
    load_use = valid_e && (opcode2 == OP_LOAD) && (rd_e != 5'd0) && valid_d &&
               ((uses_rs1 && (rs1_d == rd_e)) || (uses_rs2 && (rs2_d == rd_e)));
    stall    = load_use && !redirect;
  end

  // Advance the stage registers: a redirect flushes D and E, a stall holds D and bubbles E, otherwise everything shifts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d <= NOP;
      instr_e <= NOP;
      instr_m <= NOP;
      instr_w <= NOP;
      pc_d    <= 32'd0;
      pc_e    <= 32'd0;
      pc_m    <= 32'd0;
      pc_w    <= 32'd0;
      valid_d <= 1'b0;
      valid_e <= 1'b0;
      valid_m <= 1'b0;
      valid_w <= 1'b0;
    end else begin
      instr_m <= instr_e;
      pc_m    <= pc_e;
      valid_m <= valid_e;
      instr_w <= instr_m;
      pc_w    <= pc_m;
      valid_w <= valid_m;
      if (redirect) begin
        instr_d <= NOP;
        pc_d    <= pc_f;
        valid_d <= 1'b0;
        instr_e <= NOP;
        pc_e    <= pc_d;
        valid_e <= 1'b0;
      end else if (stall) begin
        instr_e <= NOP;
        pc_e    <= pc_d;
        valid_e <= 1'b0;
      end else begin
        instr_d <= instr_f;
        pc_d    <= pc_f;
        valid_d <= valid_f;
        instr_e <= instr_d;
        pc_e    <= pc_d;
        valid_e <= valid_d;
      end
    end
  end

  // Count every valid instruction leaving W; bubbles carry valid=0 and never count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= 32'd0;
    end else if (valid_w) begin
      retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_pipe_regs.sv
// tb_instr_pipe_regs
// Directed bench for instr_pipe_regs: reset state, straight-line flow,
// load-use stalls, false-hazard filtering, redirect squash and the
// redirect-over-stall priority.
module tb_instr_pipe_regs;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_X5  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X0  = 32'h00700333; // add  x6,x0,x7
  localparam logic [31:0] LUI_X5  = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] SW_X5   = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] BEQ     = 32'h00208463; // beq  x1,x2,8

  logic        clk;
  logic        rst;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        valid_f;
  logic        redirect;
  logic        stall;
  logic [31:0] instr_d, instr_e, instr_m, instr_w;
  logic [31:0] pc_d, pc_e, pc_m, pc_w;
  logic        valid_d, valid_e, valid_m, valid_w;
  logic [6:0]  opcode, opcode1, opcode2, opcode3, opcode4;
  logic [31:0] retired;

  int checkCount = 0;
  int errorCount = 0;

  instr_pipe_regs #(.NOP(NOP)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr_f  (instr_f),
    .pc_f     (pc_f),
    .valid_f  (valid_f),
    .redirect (redirect),
    .stall    (stall),
    .instr_d  (instr_d),
    .instr_e  (instr_e),
    .instr_m  (instr_m),
    .instr_w  (instr_w),
    .pc_d     (pc_d),
    .pc_e     (pc_e),
    .pc_m     (pc_m),
    .pc_w     (pc_w),
    .valid_d  (valid_d),
    .valid_e  (valid_e),
    .valid_m  (valid_m),
    .valid_w  (valid_w),
    .opcode   (opcode),
    .opcode1  (opcode1),
    .opcode2  (opcode2),
    .opcode3  (opcode3),
    .opcode4  (opcode4),
    .retired  (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] makeAddi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid, input logic redir);
    instr_f  = instr;
    pc_f     = pc;
    valid_f  = valid;
    redirect = redir;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(NOP, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadPair(input string tag, input logic [31:0] first,
                          input logic [31:0] second, input logic expStall);
    doReset();
    applyStimulus(first, 32'h500, 1'b1, 1'b0);
    tick();
    applyStimulus(second, 32'h504, 1'b1, 1'b0);
    tick();
    applyStimulus(NOP, 32'd0, 1'b0, 1'b0);
    checkOutput(tag, {31'd0, stall}, {31'd0, expStall});
  endtask

  initial begin
    rst      = 1'b1;
    instr_f  = NOP;
    pc_f     = 32'd0;
    valid_f  = 1'b0;
    redirect = 1'b0;

    // reset state
    #12;
    checkOutput("rst_valid_d", {31'd0, valid_d}, 32'd0);
    checkOutput("rst_valid_w", {31'd0, valid_w}, 32'd0);
    checkOutput("rst_opcode1", {25'd0, opcode1}, 32'h13);
    checkOutput("rst_opcode4", {25'd0, opcode4}, 32'h13);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // straight-line: five ADDIs at pc 0,4,8,12,16
    for (int i = 0; i < 9; i++) begin
      if (i < 5) applyStimulus(makeAddi(5'(i + 1), 12'(i + 1)), 32'(4 * i), 1'b1, 1'b0);
      else       applyStimulus(NOP, 32'd0, 1'b0, 1'b0);
      checkOutput("line_stall", {31'd0, stall}, 32'd0);
      tick();
      if (i == 3) begin
        checkOutput("line_instr_w", instr_w, makeAddi(5'd1, 12'd1));
        checkOutput("line_pc_w", pc_w, 32'd0);
      end
      if (i == 7) checkOutput("line_retired_early", retired, 32'd4);
    end
    checkOutput("line_retired", retired, 32'd5);

    // keep the pipe full until retired reaches 7, then reset between edges
    for (int i = 0; i < 6; i++) begin
      applyStimulus(makeAddi(5'd9, 12'(i)), 32'h40 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    checkOutput("full_retired", retired, 32'd7);
    checkOutput("full_valid_w", {31'd0, valid_w}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valids", {28'd0, valid_d, valid_e, valid_m, valid_w}, 32'd0);
    checkOutput("midrst_opcode2", {25'd0, opcode2}, 32'h13);
    checkOutput("midrst_opcode3", {25'd0, opcode3}, 32'h13);
    checkOutput("midrst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // load-use: lw x5 then add x6,x5,x7
    applyStimulus(LW_X5, 32'h100, 1'b1, 1'b0);
    checkOutput("lu_opcode_f", {25'd0, opcode}, 32'h03);
    tick();
    applyStimulus(ADD_X5, 32'h104, 1'b1, 1'b0);
    checkOutput("lu_stall_c1", {31'd0, stall}, 32'd0);
    tick();
    applyStimulus(makeAddi(5'd9, 12'd9), 32'h108, 1'b1, 1'b0);
    checkOutput("lu_stall_c2", {31'd0, stall}, 32'd1);
    tick();
    checkOutput("lu_hold_d", instr_d, ADD_X5);
    checkOutput("lu_bubble_e", instr_e, NOP);
    checkOutput("lu_bubble_valid_e", {31'd0, valid_e}, 32'd0);
    checkOutput("lu_bubble_pc_e", pc_e, 32'h104);
    checkOutput("lu_load_m", instr_m, LW_X5);
    checkOutput("lu_stall_c3", {31'd0, stall}, 32'd0);
    tick();
    applyStimulus(NOP, 32'd0, 1'b0, 1'b0);
    tick();
    checkOutput("lu_w_bubble", instr_w, NOP);
    checkOutput("lu_w_bubble_valid", {31'd0, valid_w}, 32'd0);
    tick();
    checkOutput("lu_w_add", instr_w, ADD_X5);
    checkOutput("lu_w_add_valid", {31'd0, valid_w}, 32'd1);

    // false-hazard filtering
    loadPair("nohaz_x0", LW_X0, ADD_X0, 1'b0);
    loadPair("nohaz_lui", LW_X5, LUI_X5, 1'b0);
    loadPair("haz_store", LW_X5, SW_X5, 1'b1);

    // redirect: branch in E squashes D and E
    doReset();
    applyStimulus(BEQ, 32'h200, 1'b1, 1'b0);
    tick();
    applyStimulus(makeAddi(5'd10, 12'd1), 32'h204, 1'b1, 1'b0);
    tick();
    applyStimulus(makeAddi(5'd11, 12'd2), 32'h208, 1'b1, 1'b1);
    tick();
    checkOutput("rd_instr_d", instr_d, NOP);
    checkOutput("rd_valid_d", {31'd0, valid_d}, 32'd0);
    checkOutput("rd_pc_d", pc_d, 32'h208);
    checkOutput("rd_instr_e", instr_e, NOP);
    checkOutput("rd_valid_e", {31'd0, valid_e}, 32'd0);
    checkOutput("rd_pc_e", pc_e, 32'h204);
    checkOutput("rd_branch_m", instr_m, BEQ);
    checkOutput("rd_valid_m", {31'd0, valid_m}, 32'd1);
    applyStimulus(makeAddi(5'd12, 12'd3), 32'h300, 1'b1, 1'b0);
    tick();
    checkOutput("rd_target_d", pc_d, 32'h300);
    applyStimulus(NOP, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("rd_retired", retired, 32'd2);

    // load-use and redirect together: flush wins
    doReset();
    applyStimulus(LW_X5, 32'h400, 1'b1, 1'b0);
    tick();
    applyStimulus(ADD_X5, 32'h404, 1'b1, 1'b0);
    tick();
    applyStimulus(makeAddi(5'd13, 12'd4), 32'h408, 1'b1, 1'b0);
    checkOutput("sim_stall_noredir", {31'd0, stall}, 32'd1);
    applyStimulus(makeAddi(5'd13, 12'd4), 32'h408, 1'b1, 1'b1);
    checkOutput("sim_stall_redir", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("sim_instr_d", instr_d, NOP);
    checkOutput("sim_pc_d", pc_d, 32'h408);
    checkOutput("sim_valid_d", {31'd0, valid_d}, 32'd0);
    checkOutput("sim_instr_e", instr_e, NOP);
    checkOutput("sim_pc_e", pc_e, 32'h404);
    checkOutput("sim_load_m", instr_m, LW_X5);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
